// File: rtl/wallace_mul_arbiter.sv
// wallace_mul_arbiter
//   Shares one combinational 16x16 Wallace-tree multiplier among NREQ
//   requesters. Round-robin grant in IDLE, operands registered on the
//   request handshake, product registered in MUL, response held in HOLD
//   until the consumer accepts it.
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req_valid/req_ready per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         packed operands, requester i at [16*i+15:16*i]
//   rsp_valid/rsp_ready response handshake
//   rsp_z/rsp_id        unsigned product and the id of the issuing requester
//   op_count            completed-response counter, wraps modulo 2^16

// wallace_16X16
//   Unsigned 16x16 -> 32 combinational multiplier. Partial products are
//   reduced with rows of 3:2 carry-save compressors (16->11->8->6->4->3->2
//   rows) followed by one final carry-propagate add.
// Ports
//   a_i, b_i  operands
//   z_o       full-width product
module wallace_16X16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [31:0] z_o
);
    // Two spare entries let the 3:2 grouping index past the live rows safely.
    logic [31:0] rows [18];
    logic [31:0] nxt  [18];
    int unsigned n;
    int unsigned m;

    always_comb begin
        rows = '{default: '0};
        nxt  = '{default: '0};
        n    = 16;
        m    = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            rows[i] = {16'b0, a_i & {16{b_i[i]}}} << i;
        end
        // Six reduction layers; the live row count shrinks each layer and
        // leftover rows that do not fill a 3-group pass straight through.
        for (int unsigned s = 0; s < 6; s++) begin
            nxt = '{default: '0};
            m   = 0;
            for (int unsigned g = 0; g < 6; g++) begin
                if (3 * g + 2 < n) begin
                    nxt[5'(m)]     = rows[5'(3*g)] ^ rows[5'(3*g+1)] ^ rows[5'(3*g+2)];
                    nxt[5'(m + 1)] = ((rows[5'(3*g)]   & rows[5'(3*g+1)]) |
                                      (rows[5'(3*g)]   & rows[5'(3*g+2)]) |
                                      (rows[5'(3*g+1)] & rows[5'(3*g+2)])) << 1;
                    m = m + 2;
                end else begin
                    if (3 * g < n) begin
                        nxt[5'(m)] = rows[5'(3*g)];
                        m = m + 1;
                    end
                    if (3 * g + 1 < n) begin
                        nxt[5'(m)] = rows[5'(3*g+1)];
                        m = m + 1;
                    end
                end
            end
            rows = nxt;
            n    = m;
        end
        z_o = rows[0] + rows[1];
    end
endmodule

module wallace_mul_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_z,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          op_count
);
    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t             state_q, state_d;
    logic [15:0]        a_q, a_d, b_q, b_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic [31:0]        z_q, z_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [15:0]        op_count_q, op_count_d;
    logic [31:0]        prod;
    logic [2*NREQ-1:0]  rot;
    logic               grant_vld;
    logic [IDW-1:0]     grant;

    wallace_16X16 u_mul (
        .a_i (a_q),
        .b_i (b_q),
        .z_o (prod)
    );

    // Rotate the request vector so bit k is requester (rr_q + k) mod NREQ;
    // the lowest set bit then gives the round-robin winner.
    always_comb begin
        rot       = {req_valid, req_valid} >> rr_q;
        grant_vld = 1'b0;
        grant     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!grant_vld && rot[k]) begin
                grant_vld = 1'b1;
                grant     = IDW'((32'(rr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rr_d        = rr_q;
        z_d         = z_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready = NREQ'(1) << grant;
                    a_d       = req_a[32'(grant)*16 +: 16];
                    b_d       = req_b[32'(grant)*16 +: 16];
                    id_d      = grant;
                    rr_d      = IDW'((32'(grant) + 1) % NREQ);
                    state_d   = MUL;
                end
            end
            MUL: begin
                z_d         = prod;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rr_q        <= '0;
            z_q         <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
            z_q         <= z_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_z     = z_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;
endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Directed and randomized bench for wallace_mul_arbiter. Expected grants,
// products, latencies and counter values come from a small reference model
// (round-robin scan, plain multiplication, modular counters).
module tb_wallace_mul_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [16*NREQ-1:0]  req_a;
    logic [16*NREQ-1:0]  req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_z;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         op_count;

    wallace_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;
    int          m_rr     = 0;
    logic [15:0] m_cnt    = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    // One complete transaction: handshake, MUL, HOLD for 'hold' stalled
    // cycles, then accept. Operands and req_valid are scrambled after the
    // handshake to show they are not re-sampled.
    task automatic run_op(input logic [NREQ-1:0] v, input logic [16*NREQ-1:0] a,
                          input logic [16*NREQ-1:0] b, input int hold, input string tag);
        int          g;
        logic [31:0] prod;
        g = model_grant(v, m_rr);
        @(negedge clk);
        req_valid = v; req_a = a; req_b = b; rsp_ready = 1'b0;
        #1;
        if (g < 0) begin
            check({tag, "/idle_ready"}, 32'(req_ready), 32'd0);
            req_valid = '0;
            return;
        end
        prod = 32'(a[16*g +: 16]) * 32'(b[16*g +: 16]);
        check({tag, "/grant"}, 32'(req_ready), 32'(1) << g);
        @(negedge clk);
        req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
        req_valid = NREQ'($urandom);
        #1;
        check({tag, "/mul_ready"}, 32'(req_ready), 32'd0);
        check({tag, "/mul_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "/t2_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "/z"}, rsp_z, prod);
        check({tag, "/id"}, 32'(rsp_id), 32'(g));
        check({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
        repeat (hold) begin
            @(negedge clk);
            req_valid = NREQ'($urandom);
            #1;
            check({tag, "/stall_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "/stall_z"}, rsp_z, prod);
            check({tag, "/stall_id"}, 32'(rsp_id), 32'(g));
            check({tag, "/stall_ready"}, 32'(req_ready), 32'd0);
            check({tag, "/stall_cnt"}, 32'(op_count), 32'(m_cnt));
        end
        rsp_ready = 1'b1;
        req_valid = '1;
        #1;
        check({tag, "/accept_ready"}, 32'(req_ready), 32'd0);
        check({tag, "/accept_cnt"}, 32'(op_count), 32'(m_cnt));
        @(negedge clk);
        req_valid = '0; rsp_ready = 1'b0;
        m_cnt = m_cnt + 16'd1;
        m_rr  = (g + 1) % NREQ;
        #1;
        check({tag, "/done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "/done_cnt"}, 32'(op_count), 32'(m_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16*NREQ-1:0] ta, tb;
        logic [31:0]        pz [NREQ];
        int                 ex;

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset/valid", 32'(rsp_valid), 32'd0);
        check("reset/z", rsp_z, 32'd0);
        check("reset/id", 32'(rsp_id), 32'd0);
        check("reset/cnt", 32'(op_count), 32'd0);
        check("reset/ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Max operands, requester 0.
        run_op(4'b0001, {48'h0, 16'hFFFF}, {48'h0, 16'hFFFF}, 0, "t1");
        // Requester 1 then requester 2.
        run_op(4'b0010, {32'h0, 16'h0001, 16'h0}, {32'h0, 16'h0001, 16'h0}, 0, "t2a");
        run_op(4'b0100, {16'h0, 16'h1001, 32'h0}, {16'h0, 16'h1001, 32'h0}, 1, "t2b");
        // Five-cycle stall in HOLD, requester 3.
        run_op(4'b1000, {16'hBEEF, 48'h0}, {16'h1234, 48'h0}, 5, "t4");

        // All requesters continuously valid with rsp_ready high: one grant
        // every third cycle, walking 0,1,2,3,0.
        ta = {$urandom, $urandom}; tb = {$urandom, $urandom};
        for (int i = 0; i < NREQ; i++) pz[i] = 32'(ta[16*i +: 16]) * 32'(tb[16*i +: 16]);
        @(negedge clk);
        req_valid = '1; req_a = ta; req_b = tb; rsp_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            #1;
            ex = (k / 3) % NREQ;
            check("t3/ready", 32'(req_ready), (k % 3 == 0) ? (32'(1) << ex) : 32'd0);
            check("t3/valid", 32'(rsp_valid), (k % 3 == 2) ? 32'd1 : 32'd0);
            if (k % 3 == 2) begin
                check("t3/id", 32'(rsp_id), 32'(ex));
                check("t3/z", rsp_z, pz[ex]);
            end
            @(negedge clk);
        end
        req_valid = '0; rsp_ready = 1'b0;
        m_cnt = m_cnt + 16'd5;
        m_rr  = 1;
        #1;
        check("t3/cnt", 32'(op_count), 32'(m_cnt));

        // Reset while the operation is in MUL.
        @(negedge clk);
        req_valid = 4'b0100; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
        #1;
        check("t5/grant", 32'(req_ready), 32'(1) << model_grant(4'b0100, m_rr));
        @(negedge clk);
        rst = 1'b1; req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        m_rr = 0; m_cnt = '0;
        #1;
        check("t5/valid", 32'(rsp_valid), 32'd0);
        check("t5/z", rsp_z, 32'd0);
        check("t5/id", 32'(rsp_id), 32'd0);
        check("t5/cnt", 32'(op_count), 32'd0);
        @(negedge clk);
        #1;
        check("t5/no_pulse", 32'(rsp_valid), 32'd0);
        run_op('1, {$urandom, $urandom}, {$urandom, $urandom}, 0, "t5r");

        // Counter wrap from a preloaded 16'hFFFF.
        @(negedge clk);
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        m_cnt = 16'hFFFF;
        #1;
        check("t6/preload", 32'(op_count), 32'(m_cnt));
        @(negedge clk);
        #1;
        check("t6/hold", 32'(op_count), 32'(m_cnt));
        run_op(4'b0100, {$urandom, $urandom}, {$urandom, $urandom}, 0, "t6");
        check("t6/wrap", 32'(op_count), 32'd0);

        // Randomized traffic, including empty request cycles.
        repeat (40) begin
            run_op(NREQ'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(0, 2)), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
